// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: issues one word request per PC, holds the returned
// instruction in IR for decode, and pulses pc_adv once per captured instruction.
module ifetch_unit #(
  parameter int FETCH_TIMEOUT = 255,
  parameter int CNT_W         = 16
) (
  input  logic        clk,
  input  logic        ReSetN,
  input  logic [31:0] PC,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] IR,
  output logic [31:0] IR_PC,
  output logic [31:0] IR_PC4,
  output logic        pc_adv,
  output logic        fetch_err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] DROP = 3'd2;
  localparam logic [2:0] FULL = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(FETCH_TIMEOUT - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      nextAddr;
  logic             timedOut;

  // The PC unit only registers the advance at the end of the pc_adv cycle, so
  // a back-to-back fetch in that cycle takes the sequential address directly.
  assign nextAddr = pc_adv ? IR_PC4 : PC;
  assign timedOut = (cnt == CntLast);

  always_ff @(posedge clk or negedge ReSetN) begin
    if (!ReSetN) begin
      state     <= IDLE;
      cnt       <= '0;
      imem_req  <= 1'b0;
      imem_addr <= 32'd0;
      ir_valid  <= 1'b0;
      IR        <= 32'd0;
      IR_PC     <= 32'd0;
      IR_PC4    <= 32'd0;
      pc_adv    <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      pc_adv <= 1'b0;
      case (state)
        IDLE: begin
          if (!stall && !flush) begin
            if (PC[1:0] != 2'b00) begin
              fetch_err <= 1'b1;
              state     <= ERR;
            end else begin
              imem_addr <= PC;
              imem_req  <= 1'b1;
              cnt       <= '0;
              state     <= REQ;
            end
          end
        end

        // DROP behaves like REQ except that the returned word is thrown away
        REQ, DROP: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
            if (state == REQ && !flush) begin
              IR       <= imem_rdata;
              IR_PC    <= imem_addr;
              IR_PC4   <= imem_addr + 32'd4;
              ir_valid <= 1'b1;
              pc_adv   <= 1'b1;
              state    <= FULL;
            end
          end else if (timedOut) begin
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
            state     <= ERR;
          end else begin
            cnt <= cnt + 1'b1;
            if (state == REQ && flush) begin
              state <= DROP;
            end
          end
        end

        FULL: begin
          if (flush) begin
            ir_valid <= 1'b0;
            state    <= IDLE;
          end else if (ir_ready) begin
            ir_valid <= 1'b0;
            if (stall) begin
              state <= IDLE;
            end else if (nextAddr[1:0] != 2'b00) begin
              fetch_err <= 1'b1;
              state     <= ERR;
            end else begin
              imem_addr <= nextAddr;
              imem_req  <= 1'b1;
              cnt       <= '0;
              state     <= REQ;
            end
          end
        end

        ERR: begin
          imem_req  <= 1'b0;
          ir_valid  <= 1'b0;
          fetch_err <= 1'b1;
        end

        default: begin
          imem_req  <= 1'b0;
          ir_valid  <= 1'b0;
          fetch_err <= 1'b1;
          state     <= ERR;
        end
      endcase
    end
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC unit.
- Samples the current PC and issues a word request to instruction memory over a req/ack handshake.
- Holds the returned instruction in IR for the decode stage under a valid/ready handshake.
- Pulses pc_adv so the PC unit steps to the next address only after a fetch completes.
- Handles redirect flushes and memory timeouts.

Parameters:
FETCH_TIMEOUT, 255, max cycles in REQ without imem_ack before fatal error (1..65535)
CNT_W, 16, width of timeout counter

Ports:
clk  in  1  system clock, all state on posedge
ReSetN  in  1  asynchronous, active-low reset
PC  in  32  current PC from PC unit
stall  in  1  hazard stall; blocks new requests only
flush  in  1  redirect (branch/jump taken); discard in-flight/held instruction
imem_req  out  1  request to instruction memory
imem_addr  out  32  word address of request
imem_ack  in  1  memory has data on imem_rdata this cycle
imem_rdata  in  32  instruction word
ir_valid  out  1  IR holds a valid instruction for decode
ir_ready  in  1  decode accepts IR this cycle
IR  out  32  fetched instruction
IR_PC  out  32  address of IR
IR_PC4  out  32  IR_PC + 4, mod 2^32
pc_adv  out  1  one-cycle pulse: PC unit may advance
fetch_err  out  1  sticky fatal error (misaligned PC or timeout)

Behaviour:
- Reset (ReSetN=0, async): state IDLE. imem_req, imem_addr, ir_valid, IR, IR_PC, IR_PC4, pc_adv, fetch_err, timeout counter all 0. Takes effect immediately even mid-request; no retraction handshake.
- All outputs are registered; states IDLE, REQ, DROP, FULL, ERR.
- IDLE:
  - If stall or flush: stay.
  - Else if PC[1:0]!=0: go ERR, fetch_err<=1.
  - Else: imem_addr<=PC, imem_req<=1, counter<=0, go REQ.
- REQ:
  - imem_req=1 and imem_addr held stable until imem_ack sampled high.
  - ack & !flush: IR<=imem_rdata, IR_PC<=imem_addr, IR_PC4<=imem_addr+4 (32-bit wrap: 0xFFFFFFFC -> 0x00000000), ir_valid<=1, imem_req<=0, pc_adv<=1 for exactly one cycle, go FULL.
  - ack & flush same cycle: data discarded, imem_req<=0, no pc_adv, go IDLE.
  - !ack & flush: go DROP. The request cannot be withdrawn, so imem_req stays 1.
  - !ack & !flush: counter+1. If counter reaches FETCH_TIMEOUT-1 without ack: imem_req<=0, fetch_err<=1, go ERR.
- DROP:
  - imem_req=1 until ack; on ack discard data, imem_req<=0, go IDLE. No pc_adv, ir_valid stays 0.
  - Further flushes are ignored; the timeout rule applies as in REQ.
- FULL:
  - IR, IR_PC, IR_PC4 stable while ir_valid=1.
  - flush (priority over ir_ready): ir_valid<=0, go IDLE.
  - ir_ready & !flush: ir_valid<=0. If !stall: issue next request from PC (updated via pc_adv) in the same transition, go REQ. Else go IDLE.
  - !ir_ready: hold.
- ERR: imem_req=0, ir_valid=0, pc_adv=0, fetch_err=1. Only reset exits; flush and stall are ignored.
- pc_adv never asserts outside the REQ->FULL transition; at most one pc_adv per accepted instruction.
- stall never aborts an in-flight request or invalidates IR.
- Throughput: with zero-wait memory (ack the cycle after req) and ir_ready held high, one instruction per 3 cycles.

Test Plan:
- Reset, PC=0x00000000, ack one cycle after req, rdata=0x8C080004, ir_ready=1 -> imem_addr=0x0; IR=0x8C080004, IR_PC=0x0, IR_PC4=0x4; single pc_adv pulse; next imem_addr=0x4.
- PC=0x00400010, ir_ready=0 for 5 cycles after ir_valid -> IR and IR_PC held, no new imem_req, no second pc_adv; req issued the cycle after ir_ready=1.
- flush asserted the 2nd cycle of REQ, ack on 4th cycle -> imem_req held through ack, no ir_valid, no pc_adv, returns to IDLE; next fetch uses new PC=0x00400100.
- flush and imem_ack in the same cycle -> no ir_valid, no pc_adv, IDLE. flush and ir_ready same cycle in FULL -> ir_valid drops, no new req that cycle.
- PC=0xFFFFFFFC fetch -> IR_PC4=0x00000000. PC=0x00000002 -> no imem_req, fetch_err=1 sticky until ReSetN low.
- FETCH_TIMEOUT=8, ack never arrives -> imem_req drops and fetch_err=1 after 8 REQ cycles. ReSetN pulled low mid-REQ -> all outputs 0 asynchronously, before the next clock edge.
